nice_result_bridge: RTL and testbench
=====================================

// Module: nice_result_bridge
// PURPOSE
//  Downstream of the CNN core top: captures each classification result (o_result_data/_valid)
//  into a small FIFO and serves it to the host through a valid/ready request/response port.
//  Also drives the core's start (enable) level from host commands. Results are synchronous to i_clk.
// PARAMETERS
//  RW      5    result width (matches core o_result_data)
//  DEPTH   4    result FIFO depth, power of 2, >=2
//  XLEN    32   response data width, >=16
//  TIMEOUT 1024 max wait cycles for READ on empty FIFO, >=2
// PORTS
//  i_clk          in  1       clock
//  i_rst          in  1       synchronous reset, active-high
//  i_req_valid    in  1       host request valid
//  o_req_ready    out 1       request accepted when valid&ready
//  i_req_op       in  2       0=START 1=READ 2=STATUS 3=STOP
//  o_rsp_valid    out 1       response valid, held until i_rsp_ready
//  i_rsp_ready    in  1       host response ready
//  o_rsp_data     out XLEN    response payload
//  o_rsp_err      out 1       READ timed out
//  i_result_data  in  RW      core result
//  i_result_valid in  1       core result valid, 1-cycle pulse per result
//  o_core_start   out 1       level enable to core i_start
//  o_fifo_count   out CW      entries held, CW=$clog2(DEPTH)+1
//  o_overflow     out 1       sticky: result dropped on full FIFO
// BEHAVIOUR
//  Reset (sync, i_rst=1 at posedge): all outputs 0 except o_req_ready=1; FIFO empty; FSM IDLE;
//   timer 0. Reset mid-transaction discards any pending response.
//  FSM IDLE/WAIT/RESP. o_req_ready=1 only in IDLE. Accept = i_req_valid & o_req_ready.
//  IDLE, accept in cycle N:
//   START : o_core_start<=1, FIFO flushed, overflow cleared, data=0 -> RESP.
//   STOP  : o_core_start<=0, FIFO untouched, data=0 -> RESP.
//   STATUS: data={0, count[CW-1:0] at bits[8+:CW], overflow bit1, core_start bit0},
//           sampled at cycle N (pre-update) -> RESP.
//   READ  : FIFO non-empty -> pop head, data={0,head} -> RESP; empty -> WAIT, timer<=0.
//  o_rsp_valid rises at N+1 (1-cycle latency) for all non-waiting ops.
//  WAIT: timer+1 each cycle; if FIFO non-empty -> pop, data={0,head}, err=0 -> RESP;
//   else if timer==TIMEOUT-1 -> data=0, err=1 -> RESP. Non-empty has priority over timeout.
//  RESP: o_rsp_valid=1, data/err stable until i_rsp_ready=1; then IDLE next cycle.
//   o_rsp_err is 0 for all ops except a timed-out READ.
//  FIFO: push on i_result_valid. Result pushed in cycle N is poppable from N+1.
//   Full & push & no pop: result dropped, o_overflow<=1 (sticky until START or reset).
//   Full & push & pop same cycle: both happen, count unchanged, no overflow.
//   Push in same cycle as START accept: flush wins, result discarded, no overflow.
//   Pointers wrap modulo DEPTH; count 0..DEPTH.
//  Results arrive regardless of o_core_start; the core gates itself.
// TESTING
//  1 reset then STATUS -> rsp at +1 cycle, data=0x0, err=0; o_req_ready=1 after reset.
//  2 START, push results 3,7 -> READ twice returns 0x3 then 0x7; STATUS count=0, bit0=1.
//  3 READ on empty, push 0x12 after 10 cycles -> rsp data=0x12, err=0, ~11 cycles after accept.
//  4 READ on empty, no push (TIMEOUT=16) -> rsp err=1, data=0 exactly 17 cycles after accept.
//  5 push 5 results with DEPTH=4 -> count=4, overflow=1, READ order 1st..4th; START clears both.
//  6 hold i_rsp_ready=0 for 5 cycles -> rsp_valid/data stable, req_ready=0; push while full+pop ok.

Source files
------------

// File: rtl/nice_result_bridge.sv
// Bridges CNN core classification results to a host request/response port.
// Results are queued in a small FIFO; host commands START/STOP/STATUS/READ.
module nice_result_bridge #(
  parameter int RW      = 5,
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [1:0]               i_req_op,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [XLEN-1:0]          o_rsp_data,
  output logic                     o_rsp_err,
  input  logic [RW-1:0]            i_result_data,
  input  logic                     i_result_valid,
  output logic                     o_core_start,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_READ   = 2'd1,
    OP_STATUS = 2'd2,
    OP_STOP   = 2'd3
  } op_t;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } rsp_t;

  state_t          state_q, state_d;
  rsp_t            rsp_q, rsp_d;
  logic            start_q, start_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ovf_q;

  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;

  logic            accept, empty, full;
  logic            pop, flush, push_ok;
  logic [RW-1:0]   head;

  assign accept  = i_req_valid && (state_q == IDLE);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = i_result_valid && (!full || pop);

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    start_d = start_q;
    timer_d = timer_q;
    pop     = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_d   = '0;
          state_d = RESP;
          unique case (op_t'(i_req_op))
            OP_START: begin
              start_d = 1'b1;
              flush   = 1'b1;
            end
            OP_STOP: start_d = 1'b0;
            OP_STATUS: begin
              rsp_d.data[8 +: CW] = count_q;
              rsp_d.data[1]       = ovf_q;
              rsp_d.data[0]       = start_q;
            end
            OP_READ: begin
              if (!empty) begin
                pop                 = 1'b1;
                rsp_d.data[RW-1:0]  = head;
              end else begin
                state_d = WAIT;
                timer_d = '0;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result arriving on the final cycle still beats the timeout.
        if (!empty) begin
          pop                = 1'b1;
          rsp_d              = '0;
          rsp_d.data[RW-1:0] = head;
          state_d            = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_d     = '0;
          rsp_d.err = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rsp_q   <= '0;
      start_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      start_q <= start_d;
      timer_q <= timer_d;
    end
  end

  // FIFO control; flush from START overrides any concurrent push.
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (i_result_valid && full && !pop) ovf_q <= 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= i_result_data;
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_rsp_valid  = (state_q == RESP);
  assign o_rsp_data   = rsp_q.data;
  assign o_rsp_err    = rsp_q.err;
  assign o_core_start = start_q;
  assign o_fifo_count = count_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_nice_result_bridge.sv
// Scoreboard bench for nice_result_bridge: expected responses queued at request time.
module tb_nice_result_bridge;
  localparam int RW = 5, DEPTH = 4, XLEN = 32, TIMEOUT = 16, CW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]      req_op;
  logic [XLEN-1:0] rsp_data;
  logic [RW-1:0]   res_data;
  logic            res_valid, core_start, overflow;
  logic [CW-1:0]   fifo_count;

  always #5 clk = ~clk;

  nice_result_bridge #(.RW(RW), .DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .i_result_data(res_data), .i_result_valid(res_valid),
    .o_core_start(core_start), .o_fifo_count(fifo_count), .o_overflow(overflow)
  );

  typedef struct {
    logic            err;
    logic [XLEN-1:0] data;
    int              lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [RW-1:0] m_q[$];
  logic          m_start, m_ovf;
  int            n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [RW-1:0] d);
    if (m_q.size() < DEPTH) m_q.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic push_res(input logic [RW-1:0] d);
    @(negedge clk);
    res_valid = 1'b1; res_data = d;
    @(posedge clk); #1 res_valid = 1'b0;
    model_push(d);
  endtask

  // Drive one request (optionally with a result push in the same cycle).
  task automatic drive(input logic [1:0] op, input logic pv, input logic [RW-1:0] pd);
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_op = op;
    res_valid = pv;   res_data = pd;
    @(posedge clk); #1 req_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op);
    exp_t e;
    e.err = 1'b0; e.data = '0; e.lat = 1;
    case (op)
      2'd0: begin m_start = 1'b1; m_q.delete(); m_ovf = 1'b0; end
      2'd3: m_start = 1'b0;
      2'd2: e.data = (32'(m_q.size()) << 8) | (32'(m_ovf) << 1) | 32'(m_start);
      default: begin
        if (m_q.size() > 0) e.data = 32'(m_q.pop_front());
        else begin e.err = 1'b1; e.lat = TIMEOUT + 1; end
      end
    endcase
    exp_q.push_back(e);
    drive(op, 1'b0, '0);
  endtask

  task automatic get_rsp(input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
      return;
    end
    e = exp_q.pop_front();
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    chk("rsp_data", 64'(rsp_data), 64'(e.data));
    chk("rsp_err", 64'(rsp_err), 64'(e.err));
    if (e.lat != 0) chk("rsp_lat", 64'(lat), 64'(e.lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_data", 64'(rsp_data), 64'(e.data));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; rsp_ready = 1'b0;
    res_valid = 1'b0; res_data = '0;
    m_start = 1'b0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state and STATUS
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_core_start", 64'(core_start), 64'(0));
    chk("rst_count", 64'(fifo_count), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    send(2'd2); get_rsp(0);

    // START, two results, read them back
    send(2'd0); get_rsp(0);
    chk("core_start", 64'(core_start), 64'(1));
    push_res(5'd3); push_res(5'd7);
    send(2'd1); get_rsp(0);
    send(2'd1); get_rsp(0);
    send(2'd2); get_rsp(0);

    // READ on empty, result arrives 10 cycles after accept
    e.err = 1'b0; e.data = 32'h12; e.lat = 12;
    exp_q.push_back(e);
    drive(2'd1, 1'b0, '0);
    fork
      get_rsp(0);
      begin
        repeat (10) @(negedge clk);
        res_valid = 1'b1; res_data = 5'h12;
        @(posedge clk); #1 res_valid = 1'b0;
      end
    join

    // READ timeout
    send(2'd1); get_rsp(0);

    // overflow with five pushes
    for (int i = 1; i <= 5; i++) push_res(RW'(i));
    @(negedge clk);
    chk("full_count", 64'(fifo_count), 64'(4));
    chk("full_overflow", 64'(overflow), 64'(1));
    send(2'd2); get_rsp(0);
    for (int i = 0; i < 4; i++) begin send(2'd1); get_rsp(0); end
    push_res(5'd9);

    // START with concurrent push: flush wins
    e.err = 1'b0; e.data = '0; e.lat = 1;
    exp_q.push_back(e);
    m_start = 1'b1; m_q.delete(); m_ovf = 1'b0;
    drive(2'd0, 1'b1, 5'd10);
    get_rsp(0);
    chk("flush_count", 64'(fifo_count), 64'(0));
    chk("flush_overflow", 64'(overflow), 64'(0));
    send(2'd2); get_rsp(0);

    // full FIFO, pop and push together; held response
    for (int i = 11; i <= 14; i++) push_res(RW'(i));
    e.err = 1'b0; e.data = 32'(m_q.pop_front()); e.lat = 1;
    exp_q.push_back(e);
    m_q.push_back(5'd15);
    drive(2'd1, 1'b1, 5'd15);
    get_rsp(5);
    chk("pp_count", 64'(fifo_count), 64'(4));
    chk("pp_overflow", 64'(overflow), 64'(0));
    for (int i = 0; i < 4; i++) begin send(2'd1); get_rsp(0); end
    send(2'd3); get_rsp(0);
    send(2'd2); get_rsp(0);

    // reset while a response is pending
    send(2'd0);
    @(negedge clk);
    chk("pend_valid", 64'(rsp_valid), 64'(1));
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_start = 1'b0; m_ovf = 1'b0; m_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(1));
    chk("mid_rst_start", 64'(core_start), 64'(0));
    send(2'd2); get_rsp(0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
